// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory waits, control-transfer
// redirects and load-use interlocks into pipeline-register enables, and
// keeps a saturating count of stalled fetch cycles.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        ex_br_taken,
    input  logic        clr_cnt,
    output logic        load_if,
    output logic        load_id,
    output logic        load_ex,
    output logic        load_mem,
    output logic        load_wb,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        mem_ex_rdata_hazard,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    // state | meaning
    // RUN        | previous cycle advanced normally
    // MEM_WAIT   | previous cycle froze the pipe for a memory handshake
    // LU_BUBBLE  | previous cycle held IF/ID and inserted a bubble for load-use
    // REDIRECT   | previous cycle squashed IF/ID for a control transfer
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd1;
    localparam logic [1:0] ST_LU_BUBBLE = 2'd2;
    localparam logic [1:0] ST_REDIRECT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        pending_flush_q, pending_flush_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic memwait;
    logic lu;
    logic redirect;

    logic load_if_c, load_id_c, load_ex_c, load_mem_c, load_wb_c;
    logic bubble_ex_c, flush_id_c, hazard_c;

    // Hazard detection terms, all purely from current inputs and the pending flag.
    always_comb begin
        memwait  = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
        lu       = ex_is_load & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd)));
        redirect = ex_br_taken | pending_flush_q;
    end

    // Fixed-priority action decode; the registered state never feeds back here.
    always_comb begin
        load_if_c       = 1'b1;
        load_id_c       = 1'b1;
        load_ex_c       = 1'b1;
        load_mem_c      = 1'b1;
        load_wb_c       = 1'b1;
        bubble_ex_c     = 1'b0;
        flush_id_c      = 1'b0;
        hazard_c        = 1'b0;
        state_d         = ST_RUN;
        pending_flush_d = 1'b0;
        if (memwait) begin
            load_if_c       = 1'b0;
            load_id_c       = 1'b0;
            load_ex_c       = 1'b0;
            load_mem_c      = 1'b0;
            load_wb_c       = 1'b0;
            hazard_c        = 1'b1;
            state_d         = ST_MEM_WAIT;
            // A redirect seen while frozen is parked until the pipe moves again.
            pending_flush_d = pending_flush_q | ex_br_taken;
        end else if (redirect) begin
            bubble_ex_c = 1'b1;
            flush_id_c  = 1'b1;
            state_d     = ST_REDIRECT;
        end else if (lu) begin
            load_if_c   = 1'b0;
            load_id_c   = 1'b0;
            bubble_ex_c = 1'b1;
            state_d     = ST_LU_BUBBLE;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = 16'd0;
        end else if (!load_if_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State, pending redirect and counter registers with async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            pending_flush_q <= 1'b0;
            stall_cnt_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        load_if             = load_if_c   & reset;
        load_id             = load_id_c   & reset;
        load_ex             = load_ex_c   & reset;
        load_mem            = load_mem_c  & reset;
        load_wb             = load_wb_c   & reset;
        bubble_ex           = bubble_ex_c & reset;
        flush_id            = flush_id_c  & reset;
        mem_ex_rdata_hazard = hazard_c    & reset;
        state               = state_q;
        stall_cnt           = stall_cnt_q;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-low reset; low = in reset.
REQ-003 SHALL provide ports: id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL provide ports: id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-005 SHALL provide ports: ex_rd  input  5  and  ex_is_load  input  1  describing the instruction in EX.
REQ-006 SHALL provide ports: imem_req, imem_resp, dmem_req, dmem_resp  input  1 each  fetch and MEM-stage memory handshakes.
REQ-007 SHALL provide port: ex_br_taken  input  1  EX-stage control-transfer redirect, single-cycle pulse.
REQ-008 SHALL provide port: clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-009 SHALL provide ports: load_if, load_id, load_ex, load_mem, load_wb  output  1 each  pipeline-register load enables.
REQ-010 SHALL provide ports: bubble_ex  output  1  (NOP into ID/EX)  and  flush_id  output  1  (squash IF/ID).
REQ-011 SHALL provide port: mem_ex_rdata_hazard  output  1  lets the ID/EX register capture WB forwarding data while frozen.
REQ-012 SHALL provide ports: state  output  2  current FSM state;  stall_cnt  output  16  stalled-cycle counter.

Function
REQ-013 SHALL compute memwait = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp).
REQ-014 SHALL compute lu = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-015 SHALL compute redirect = ex_br_taken | pending_flush, where pending_flush is an internal 1-bit register.
REQ-016 SHALL apply fixed priority memwait > redirect > lu > normal in every cycle; outputs are combinational (Mealy) from inputs and pending_flush.
REQ-017 memwait: all load_*=0, bubble_ex=0, flush_id=0, mem_ex_rdata_hazard=1; pending_flush <= pending_flush | ex_br_taken; next state MEM_WAIT (2'd1).
REQ-018 redirect without memwait: all load_*=1, flush_id=1, bubble_ex=1; pending_flush <= 0; next state REDIRECT (2'd3).
REQ-019 lu only: load_if=load_id=0, load_ex=load_mem=load_wb=1, bubble_ex=1, flush_id=0; next state LU_BUBBLE (2'd2).
REQ-020 normal: all load_*=1, bubble_ex=0, flush_id=0; next state RUN (2'd0).
REQ-021 mem_ex_rdata_hazard SHALL be 1 only in memwait cycles.
REQ-022 A redirect arriving during memwait SHALL NOT be lost: it is applied in the first cycle memwait is low, and only once.
REQ-023 lu SHALL be re-evaluated every cycle; it is not latched across memwait.
REQ-024 stall_cnt SHALL increment by 1 in every cycle where load_if=0, saturate at 16'hFFFF, and not wrap.
REQ-025 clr_cnt=1 SHALL set stall_cnt to 0 on the next edge and override any increment in that cycle.
REQ-026 The state output SHALL be a trace of the previous cycle's action and SHALL NOT feed back into output decode.

Reset
REQ-027 reset low SHALL immediately set state=RUN, pending_flush=0, stall_cnt=0, without waiting for clk.
REQ-028 While reset is low, all load_*, bubble_ex, flush_id and mem_ex_rdata_hazard SHALL be 0.
REQ-029 After reset deasserts, the first edge SHALL evaluate normally; no extra idle cycle is added.
REQ-030 reset asserted during MEM_WAIT with a pending redirect SHALL discard that redirect.

Verification
REQ-031 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, no memwait -> load_if=load_id=0, bubble_ex=1, next state=2, stall_cnt +1.
REQ-032 Load to x0: same as REQ-031 with ex_rd=0 -> all load_*=1, bubble_ex=0, next state=0.
REQ-033 Redirect inside memwait: dmem_req=1, dmem_resp=0 for 3 cycles with ex_br_taken in cycle 1 -> 3 cycles of all load_*=0 and mem_ex_rdata_hazard=1; cycle 4 flush_id=1, bubble_ex=1, state=3; cycle 5 flush_id=0.
REQ-034 Simultaneous redirect and lu, no memwait -> flush_id=1, bubble_ex=1, all load_*=1; lu is ignored.
REQ-035 Saturation: 65540 consecutive memwait cycles -> stall_cnt=16'hFFFF held; clr_cnt=1 -> 0 on the next edge.
REQ-036 Async reset: reset pulsed low between edges during MEM_WAIT -> state=0 and stall_cnt=0 before the next edge, and no flush after release.
